// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture path: active-high glyph
// table (bit6=a .. bit0=g), blank codes and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h7E;
  localparam logic [6:0] SEG_HEX_1 = 7'h30;
  localparam logic [6:0] SEG_HEX_2 = 7'h6D;
  localparam logic [6:0] SEG_HEX_3 = 7'h79;
  localparam logic [6:0] SEG_HEX_4 = 7'h33;
  localparam logic [6:0] SEG_HEX_5 = 7'h5B;
  localparam logic [6:0] SEG_HEX_6 = 7'h5F;
  localparam logic [6:0] SEG_HEX_7 = 7'h70;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h7B;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;

  // No segment lit (active-high glyph form)
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Fully dark bus in active-low pin form, dp included
  localparam logic [7:0] SEG_N_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Reverse glyph lookup: active-high 7-bit abcdefg pattern to hex digit.
// o_hit is low for any pattern that is not one of the sixteen hex glyphs.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic       o_hit,
  output logic [3:0] o_hex
);

  // Exact-match table search; unknown patterns report a miss with hex 0
  always_comb begin
    o_hit = 1'b1;
    o_hex = 4'h0;
    case (i_glyph)
      SEG_HEX_0: o_hex = 4'h0;
      SEG_HEX_1: o_hex = 4'h1;
      SEG_HEX_2: o_hex = 4'h2;
      SEG_HEX_3: o_hex = 4'h3;
      SEG_HEX_4: o_hex = 4'h4;
      SEG_HEX_5: o_hex = 4'h5;
      SEG_HEX_6: o_hex = 4'h6;
      SEG_HEX_7: o_hex = 4'h7;
      SEG_HEX_8: o_hex = 4'h8;
      SEG_HEX_9: o_hex = 4'h9;
      SEG_HEX_A: o_hex = 4'hA;
      SEG_HEX_B: o_hex = 4'hB;
      SEG_HEX_C: o_hex = 4'hC;
      SEG_HEX_D: o_hex = 4'hD;
      SEG_HEX_E: o_hex = 4'hE;
      SEG_HEX_F: o_hex = 4'hF;
      default: begin
        o_hit = 1'b0;
        o_hex = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples an active-low segment bus, waits for a pattern to stay steady for
// STABLE_CYCLES samples, decodes it back to hex and offers it once over a
// valid/ready handshake. Blank patterns re-arm the emitter without output.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] hex,
  output logic       dp,
  output logic       err
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

  logic [7:0] r_s_q;
  logic [7:0] r_cnt;
  logic [7:0] r_last_emit;
  state_t     r_state;
  logic       r_out_valid;
  logic [3:0] r_hex;
  logic       r_dp;
  logic       r_err;

  logic [6:0] w_glyph;
  logic       w_hit;
  logic [3:0] w_hex;
  logic       w_blank;
  logic       w_stable;
  logic       w_differs;

  // dp (bit 0) is excluded from the glyph so it never influences hex/err
  assign w_glyph   = ~r_s_q[7:1];
  assign w_blank   = (w_glyph == SEG_BLANK);
  assign w_stable  = (r_cnt == C_STABLE);
  assign w_differs = (r_s_q != r_last_emit);

  seg7_pattern_lookup u_lookup (
    .i_glyph (w_glyph),
    .o_hit   (w_hit),
    .o_hex   (w_hex)
  );

  // Input sampling and stability counting; the counter keeps running in
  // every FSM state so a pattern can mature while an output is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_q <= SEG_N_BLANK;
      r_cnt <= 8'd0;
    end else begin
      r_s_q <= seg_n;
      if (seg_n != r_s_q)
        r_cnt <= 8'd1;
      else if (r_cnt < C_STABLE)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Capture FSM with registered outputs. IDLE applies the same acceptance
  // test as SETTLE so that a single-cycle stability window still emits one
  // edge after the counter reaches its target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_emit <= SEG_N_BLANK;
      r_out_valid <= 1'b0;
      r_hex       <= 4'h0;
      r_dp        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SETTLE: begin
          if (!w_differs) begin
            r_state <= ST_IDLE;
          end else if (w_stable) begin
            if (w_blank) begin
              r_last_emit <= SEG_N_BLANK;
              r_state     <= ST_IDLE;
            end else begin
              r_hex       <= w_hit ? w_hex : 4'h0;
              r_dp        <= ~r_s_q[0];
              r_err       <= ~w_hit;
              r_out_valid <= 1'b1;
              r_last_emit <= r_s_q;
              r_state     <= ST_HOLD;
            end
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign hex       = r_hex;
  assign dp        = r_dp;
  assign err       = r_err;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: one instance at the default
// stability window of 4 and one at a window of 1.
module tb_seg7_capture_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] seg_n;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] hex;
  logic       dp;
  logic       err;

  logic [7:0] seg_n1;
  logic       ready1;
  logic       valid1;
  logic [3:0] hex1;
  logic       dp1;
  logic       err1;

  int n_checks = 0;
  int n_pass   = 0;
  int hs0      = 0;
  int hs1      = 0;

  seg7_capture_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .hex       (hex),
    .dp        (dp),
    .err       (err)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n1),
    .out_ready (ready1),
    .out_valid (valid1),
    .hex       (hex1),
    .dp        (dp1),
    .err       (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters for both instances
  always @(posedge clk) begin
    if (out_valid && out_ready) hs0 = hs0 + 1;
    if (valid1 && ready1)       hs1 = hs1 + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s ok observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // seg_n must have been changed just before calling; covers E0..E0+4
  task automatic emit_check(input string tag, input logic [3:0] e_hex,
                            input logic e_dp, input logic e_err);
    step(4);
    chk({tag, "_early_valid"}, out_valid, 0);
    step(1);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_hex"}, hex, e_hex);
    chk({tag, "_dp"}, dp, e_dp);
    chk({tag, "_err"}, err, e_err);
  endtask

  initial begin
    bit ok;
    int h;
    reset     = 1'b1;
    seg_n     = 8'hFF;
    out_ready = 1'b0;
    seg_n1    = 8'hFF;
    ready1    = 1'b1;
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_hex", hex, 0);
    chk("rst_dp", dp, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // Digit 0 held with ready high: exactly one pulse
    h = hs0;
    seg_n = 8'h03;
    out_ready = 1'b1;
    emit_check("d0", 4'h0, 1'b0, 1'b0);
    step(1);
    chk("d0_drop", out_valid, 0);
    step(10);
    chk("d0_one_pulse", hs0 - h, 1);

    // All segments plus dp lit -> 8 with dp
    seg_n = 8'h00;
    emit_check("d8dp", 4'h8, 1'b1, 1'b0);
    step(1);
    // Only segment a lit -> illegal glyph
    seg_n = 8'h7F;
    emit_check("bad", 4'h0, 1'b0, 1'b1);
    step(1);
    chk("bad_drop", out_valid, 0);

    // Backpressure: digit 1 frozen while a newer pattern A matures
    out_ready = 1'b0;
    seg_n = 8'h9F;
    emit_check("bp1", 4'h1, 1'b0, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!(out_valid === 1'b1 && hex === 4'h1)) ok = 1'b0;
    end
    chk("bp_frozen_a", ok, 1);
    seg_n = 8'h11;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!(out_valid === 1'b1 && hex === 4'h1)) ok = 1'b0;
    end
    chk("bp_frozen_b", ok, 1);
    out_ready = 1'b1;
    step(1);
    chk("bp_gap", out_valid, 0);
    step(1);
    chk("bpA_valid", out_valid, 1);
    chk("bpA_hex", hex, 4'hA);
    step(1);
    chk("bpA_drop", out_valid, 0);

    // Digit, blank with short glitch, same digit again
    seg_n = 8'h9F;
    emit_check("rep1", 4'h1, 1'b0, 1'b0);
    step(1);
    h = hs0;
    seg_n = 8'hFF;
    step(5);
    seg_n = 8'h11;
    step(3);
    seg_n = 8'hFF;
    step(5);
    chk("blank_glitch_none", hs0 - h, 0);
    seg_n = 8'h9F;
    emit_check("rep2", 4'h1, 1'b0, 1'b0);
    step(1);

    // Reset while an output is pending
    seg_n = 8'h00;
    emit_check("pre_rst", 4'h8, 1'b1, 1'b0);
    step(1);
    out_ready = 1'b0;
    seg_n = 8'h9F;
    emit_check("pend", 4'h1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_hex", hex, 0);
    chk("arst_dp", dp, 0);
    chk("arst_err", err, 0);
    step(2);
    reset = 1'b0;
    emit_check("post_rst", 4'h1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step(1);
    chk("post_rst_drop", out_valid, 0);

    // Single-cycle window: alternating 0/1 every two cycles
    h = hs1;
    for (int k = 0; k < 6; k++) begin
      seg_n1 = (k % 2 == 1) ? 8'h9F : 8'h03;
      step(1);
      chk($sformatf("s1_low_%0d", k), valid1, 0);
      step(1);
      chk($sformatf("s1_valid_%0d", k), valid1, 1);
      chk($sformatf("s1_hex_%0d", k), hex1, (k % 2 == 1) ? 4'h1 : 4'h0);
    end
    step(3);
    chk("s1_pulses", hs1 - h, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
